// File: rtl/rvh_l1d_stb_coalesce_buf.sv
`default_nettype none
// ============================================================================
// Module   : rvh_l1d_stb_coalesce_buf
// Brief    : Line-granular store coalescing buffer; merges same-line stores
//            and drains entries in FIFO order to the L1D store port.
// Revision : 1.0 - initial release
// ============================================================================
module rvh_l1d_stb_coalesce_buf #(
    parameter int unsigned LINE_W       = 512,
    parameter int unsigned LINE_ADDR_W  = 50,
    parameter int unsigned ENTRIES      = 4,
    parameter int unsigned DRAIN_THRESH = 2,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   st_req_vld_i,
    output logic                   st_req_rdy_o,
    input  logic [LINE_ADDR_W-1:0] st_req_line_addr_i,
    input  logic [LINE_W-1:0]      st_req_data_i,
    input  logic [LINE_W/8-1:0]    st_req_byte_mask_i,
    output logic                   l1d_req_vld_o,
    input  logic                   l1d_req_rdy_i,
    output logic [LINE_ADDR_W-1:0] l1d_req_line_addr_o,
    output logic [LINE_W-1:0]      l1d_req_data_o,
    output logic [LINE_W/8-1:0]    l1d_req_byte_mask_o,
    input  logic                   flush_i,
    output logic                   empty_o
);

    localparam int unsigned c_mask_w = LINE_W / 8;
    localparam int unsigned c_ptr_w  = $clog2(ENTRIES);
    localparam int unsigned c_cnt_w  = c_ptr_w + 1;
    localparam int unsigned c_tmr_w  = $clog2(TIMEOUT + 1);

    localparam logic [c_cnt_w-1:0] c_entries = c_cnt_w'(ENTRIES);
    localparam logic [c_cnt_w-1:0] c_thresh  = c_cnt_w'(DRAIN_THRESH);
    localparam logic [c_tmr_w-1:0] c_timeout = c_tmr_w'(TIMEOUT);

    logic [ENTRIES-1:0]     r_vld;
    logic [LINE_ADDR_W-1:0] r_addr [ENTRIES];
    logic [LINE_W-1:0]      r_data [ENTRIES];
    logic [c_mask_w-1:0]    r_mask [ENTRIES];

    logic [c_ptr_w-1:0]     r_head;
    logic [c_ptr_w-1:0]     r_tail;
    logic [c_cnt_w-1:0]     r_count;
    logic [c_tmr_w-1:0]     r_timer;
    logic                   r_lock;
    logic                   r_out_vld;
    logic                   r_empty;
    logic [LINE_ADDR_W-1:0] r_out_addr;
    logic [LINE_W-1:0]      r_out_data;
    logic [c_mask_w-1:0]    r_out_mask;

    logic                   w_acc;
    logic                   w_hs;
    logic                   w_drain_go;
    logic                   w_mask_nz;
    logic [ENTRIES-1:0]     w_hit;
    logic                   w_any_hit;
    logic                   w_alloc;
    logic                   w_merge;
    logic [LINE_W-1:0]      w_bit_en;
    logic [c_cnt_w-1:0]     w_cnt_nxt;
    logic                   w_out_vld_nxt;

    assign st_req_rdy_o = (r_count < c_entries) && !flush_i;
    assign w_acc        = st_req_vld_i && st_req_rdy_o;
    assign w_hs         = r_out_vld && l1d_req_rdy_i;
    assign w_mask_nz    = |st_req_byte_mask_i;

    assign w_drain_go = (r_count != '0) && !r_out_vld &&
                        ((r_count >= c_thresh) || flush_i || (r_timer >= c_timeout));

    // The head is excluded from merging already in the drain-decision cycle,
    // because the output registers capture the head contents on that edge.
    generate
        for (genvar i = 0; i < ENTRIES; i++) begin : g_hit
            assign w_hit[i] = r_vld[i] && (r_addr[i] == st_req_line_addr_i) &&
                              !((r_lock || w_drain_go) && (r_head == c_ptr_w'(i)));
        end
    endgenerate

    generate
        for (genvar b = 0; b < c_mask_w; b++) begin : g_bit_en
            assign w_bit_en[b*8 +: 8] = {8{st_req_byte_mask_i[b]}};
        end
    endgenerate

    assign w_any_hit = |w_hit;
    assign w_alloc   = w_acc && w_mask_nz && !w_any_hit;
    assign w_merge   = w_acc && w_mask_nz && w_any_hit;

    assign w_cnt_nxt = r_count + {{c_ptr_w{1'b0}}, w_alloc} - {{c_ptr_w{1'b0}}, w_hs};

    assign w_out_vld_nxt = w_drain_go ? 1'b1 : (w_hs ? 1'b0 : r_out_vld);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (w_hs && (r_head == c_ptr_w'(i))) begin
                    r_vld[i] <= 1'b0;
                end
                if (w_alloc && (r_tail == c_ptr_w'(i))) begin
                    r_vld[i]  <= 1'b1;
                    r_addr[i] <= st_req_line_addr_i;
                    r_data[i] <= st_req_data_i;
                    r_mask[i] <= st_req_byte_mask_i;
                end
                if (w_merge && w_hit[i]) begin
                    r_data[i] <= (r_data[i] & ~w_bit_en) | (st_req_data_i & w_bit_en);
                    r_mask[i] <= r_mask[i] | st_req_byte_mask_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_timer    <= '0;
            r_lock     <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_addr <= '0;
            r_out_data <= '0;
            r_out_mask <= '0;
            r_empty    <= 1'b1;
        end else begin
            if (w_alloc) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_hs) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= w_cnt_nxt;

            if (w_hs || (r_count == '0)) begin
                r_timer <= '0;
            end else if (r_timer < c_timeout) begin
                r_timer <= r_timer + 1'b1;
            end

            if (w_drain_go) begin
                r_out_vld  <= 1'b1;
                r_lock     <= 1'b1;
                r_out_addr <= r_addr[r_head];
                r_out_data <= r_data[r_head];
                r_out_mask <= r_mask[r_head];
            end else if (w_hs) begin
                r_out_vld <= 1'b0;
                r_lock    <= 1'b0;
            end

            r_empty <= (w_cnt_nxt == '0) && !w_out_vld_nxt;
        end
    end

    assign l1d_req_vld_o       = r_out_vld;
    assign l1d_req_line_addr_o = r_out_addr;
    assign l1d_req_data_o      = r_out_data;
    assign l1d_req_byte_mask_o = r_out_mask;
    assign empty_o             = r_empty;

endmodule
`default_nettype wire

// File: tb/tb_rvh_l1d_stb_coalesce_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvh_l1d_stb_coalesce_buf
// Brief    : Scenario bench for the store coalescing buffer with a drain
//            scoreboard of expected L1D writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvh_l1d_stb_coalesce_buf;

    localparam int LINE_W = 512;
    localparam int ADDR_W = 50;
    localparam int MASK_W = LINE_W / 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
        logic [MASK_W-1:0] mask;
    } drain_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              st_req_vld_i;
    logic              st_req_rdy_o;
    logic [ADDR_W-1:0] st_req_line_addr_i;
    logic [LINE_W-1:0] st_req_data_i;
    logic [MASK_W-1:0] st_req_byte_mask_i;
    logic              l1d_req_vld_o;
    logic              l1d_req_rdy_i;
    logic [ADDR_W-1:0] l1d_req_line_addr_o;
    logic [LINE_W-1:0] l1d_req_data_o;
    logic [MASK_W-1:0] l1d_req_byte_mask_o;
    logic              flush_i;
    logic              empty_o;

    int     checks   = 0;
    int     failures = 0;
    drain_t sb[$];
    drain_t exp_d;

    rvh_l1d_stb_coalesce_buf #(
        .LINE_W      (LINE_W),
        .LINE_ADDR_W (ADDR_W),
        .ENTRIES     (4),
        .DRAIN_THRESH(2),
        .TIMEOUT     (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .st_req_vld_i       (st_req_vld_i),
        .st_req_rdy_o       (st_req_rdy_o),
        .st_req_line_addr_i (st_req_line_addr_i),
        .st_req_data_i      (st_req_data_i),
        .st_req_byte_mask_i (st_req_byte_mask_i),
        .l1d_req_vld_o      (l1d_req_vld_o),
        .l1d_req_rdy_i      (l1d_req_rdy_i),
        .l1d_req_line_addr_o(l1d_req_line_addr_o),
        .l1d_req_data_o     (l1d_req_data_o),
        .l1d_req_byte_mask_o(l1d_req_byte_mask_o),
        .flush_i            (flush_i),
        .empty_o            (empty_o)
    );

    always #5 clk = ~clk;

    // Every accepted drain is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!rst && l1d_req_vld_o && l1d_req_rdy_i) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_drain got addr=%h mask=%h, expected no drain",
                         l1d_req_line_addr_o, l1d_req_byte_mask_o);
            end else begin
                exp_d = sb.pop_front();
                if (l1d_req_line_addr_o !== exp_d.addr || l1d_req_byte_mask_o !== exp_d.mask ||
                    l1d_req_data_o !== exp_d.data) begin
                    failures++;
                    $display("FAIL drain_content got addr=%h mask=%h data=%h expected addr=%h mask=%h data=%h",
                             l1d_req_line_addr_o, l1d_req_byte_mask_o, l1d_req_data_o,
                             exp_d.addr, exp_d.mask, exp_d.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic drain_t mk(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                                  input logic [MASK_W-1:0] m);
        drain_t r;
        r.addr = a;
        r.data = d;
        r.mask = m;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [ADDR_W-1:0] a, input logic [MASK_W-1:0] m,
                            input logic [LINE_W-1:0] d);
        st_req_vld_i       = 1'b1;
        st_req_line_addr_i = a;
        st_req_byte_mask_i = m;
        st_req_data_i      = d;
        tick();
        st_req_vld_i       = 1'b0;
        st_req_byte_mask_i = '0;
        st_req_data_i      = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        st_req_vld_i = 1'b0; st_req_line_addr_i = '0; st_req_data_i = '0;
        st_req_byte_mask_i = '0; l1d_req_rdy_i = 1'b0; flush_i = 1'b0;
        repeat (3) tick();
        checks++;
        if (l1d_req_vld_o !== 1'b0 || empty_o !== 1'b1 || st_req_rdy_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctrl got vld=%b empty=%b rdy=%b expected 0 1 1",
                     l1d_req_vld_o, empty_o, st_req_rdy_o);
        end
        checks++;
        if (l1d_req_line_addr_o !== '0 || l1d_req_byte_mask_o !== '0 || l1d_req_data_o !== '0) begin
            failures++;
            $display("FAIL reset_outputs got addr=%h mask=%h expected 0 0",
                     l1d_req_line_addr_o, l1d_req_byte_mask_o);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (empty_o !== 1'b1 || st_req_rdy_o !== 1'b1) begin
            failures++;
            $display("FAIL post_reset got empty=%b rdy=%b expected 1 1", empty_o, st_req_rdy_o);
        end
    endtask

    task automatic test_single_timeout();
        logic [LINE_W-1:0] d;
        d = '0;
        d[31:0] = 32'hAABBCCDD;
        l1d_req_rdy_i = 1'b1;
        sb.push_back(mk(50'h10, d, 64'hF));
        do_store(50'h10, 64'hF, d);
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++;
            if (l1d_req_vld_o !== 1'b0) begin
                failures++;
                $display("FAIL timeout_early cycle=%0d got vld=%b expected 0", k, l1d_req_vld_o);
            end
        end
        tick();
        checks++;
        if (l1d_req_vld_o !== 1'b1) begin
            failures++;
            $display("FAIL timeout_drain got vld=%b expected 1", l1d_req_vld_o);
        end
        repeat (2) tick();
        checks++;
        if (empty_o !== 1'b1 || sb.size() != 0) begin
            failures++;
            $display("FAIL single_empty got empty=%b pending=%0d expected 1 0", empty_o, sb.size());
        end
    endtask

    task automatic test_merge();
        logic [LINE_W-1:0] d1;
        logic [LINE_W-1:0] d2;
        logic [LINE_W-1:0] de;
        d1 = '0; d1[15:0] = 16'h1111;
        d2 = '0; d2[23:0] = 24'h222299;
        de = '0; de[23:0] = 24'h222211;
        l1d_req_rdy_i = 1'b1;
        sb.push_back(mk(50'h20, de, 64'h7));
        do_store(50'h20, 64'h3, d1);
        do_store(50'h20, 64'h6, d2);
        for (int i = 0; i < 100 && (sb.size() != 0 || !empty_o); i++) tick();
        tick();
        checks++;
        if (sb.size() != 0 || empty_o !== 1'b1) begin
            failures++;
            $display("FAIL merge_done got pending=%0d empty=%b expected 0 1", sb.size(), empty_o);
        end
    endtask

    task automatic test_full_order();
        logic [LINE_W-1:0] d [4];
        logic [MASK_W-1:0] m [4];
        l1d_req_rdy_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d[i] = '0;
            d[i][31:0] = {4{8'hA0 + 8'(i)}};
            m[i] = 64'((1 << (i + 1)) - 1);
            sb.push_back(mk(50'h100 + 50'(i), d[i], m[i]));
        end
        for (int i = 0; i < 4; i++) do_store(50'h100 + 50'(i), m[i], d[i]);
        checks++;
        if (st_req_rdy_o !== 1'b0) begin
            failures++;
            $display("FAIL full_rdy got rdy=%b expected 0", st_req_rdy_o);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (l1d_req_vld_o !== 1'b1 || l1d_req_line_addr_o !== 50'h100 ||
                l1d_req_byte_mask_o !== m[0] || l1d_req_data_o !== d[0]) begin
                failures++;
                $display("FAIL held_stable cycle=%0d got vld=%b addr=%h mask=%h expected 1 100 %h",
                         k, l1d_req_vld_o, l1d_req_line_addr_o, l1d_req_byte_mask_o, m[0]);
            end
            tick();
        end
        l1d_req_rdy_i = 1'b1;
        tick();
        checks++;
        if (st_req_rdy_o !== 1'b1) begin
            failures++;
            $display("FAIL rdy_return got rdy=%b expected 1", st_req_rdy_o);
        end
        for (int i = 0; i < 200 && (sb.size() != 0 || !empty_o); i++) tick();
        checks++;
        if (sb.size() != 0 || empty_o !== 1'b1) begin
            failures++;
            $display("FAIL full_drain got pending=%0d empty=%b expected 0 1", sb.size(), empty_o);
        end
    endtask

    task automatic test_head_lock();
        logic [LINE_W-1:0] d1;
        logic [LINE_W-1:0] d2;
        d1 = '0; d1[7:0]  = 8'h5A;
        d2 = '0; d2[15:8] = 8'hA5;
        l1d_req_rdy_i = 1'b0;
        sb.push_back(mk(50'h200, d1, 64'h1));
        sb.push_back(mk(50'h200, d2, 64'h2));
        do_store(50'h200, 64'h1, d1);
        for (int i = 0; i < 40 && !l1d_req_vld_o; i++) tick();
        checks++;
        if (l1d_req_vld_o !== 1'b1) begin
            failures++;
            $display("FAIL lock_head_vld got vld=%b expected 1", l1d_req_vld_o);
        end
        do_store(50'h200, 64'h2, d2);
        checks++;
        if (l1d_req_vld_o !== 1'b1 || l1d_req_byte_mask_o !== 64'h1 || l1d_req_data_o !== d1) begin
            failures++;
            $display("FAIL lock_no_merge got vld=%b mask=%h expected 1 1",
                     l1d_req_vld_o, l1d_req_byte_mask_o);
        end
        l1d_req_rdy_i = 1'b1;
        for (int i = 0; i < 100 && (sb.size() != 0 || !empty_o); i++) tick();
        checks++;
        if (sb.size() != 0 || empty_o !== 1'b1) begin
            failures++;
            $display("FAIL lock_drain got pending=%0d empty=%b expected 0 1", sb.size(), empty_o);
        end
    endtask

    task automatic test_flush();
        logic [LINE_W-1:0] d;
        logic              pat [5];
        pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        l1d_req_rdy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = '0;
            d[LINE_W-1 -: 8] = 8'hC0 + 8'(i);
            sb.push_back(mk(50'h300 + 50'(i), d, 64'h8000_0000_0000_0000));
            do_store(50'h300 + 50'(i), 64'h8000_0000_0000_0000, d);
        end
        flush_i = 1'b1;
        #1;
        checks++;
        if (st_req_rdy_o !== 1'b0 || l1d_req_vld_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_block got rdy=%b vld=%b expected 0 1", st_req_rdy_o, l1d_req_vld_o);
        end
        l1d_req_rdy_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (l1d_req_vld_o !== pat[k]) begin
                failures++;
                $display("FAIL flush_bubble cycle=%0d got vld=%b expected %b", k, l1d_req_vld_o, pat[k]);
            end
        end
        tick();
        checks++;
        if (empty_o !== 1'b1 || sb.size() != 0 || st_req_rdy_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_empty got empty=%b pending=%0d rdy=%b expected 1 0 0",
                     empty_o, sb.size(), st_req_rdy_o);
        end
        flush_i = 1'b0;
        #1;
        checks++;
        if (st_req_rdy_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_release got rdy=%b expected 1", st_req_rdy_o);
        end
    endtask

    task automatic test_zero_mask();
        int seen;
        seen = 0;
        l1d_req_rdy_i = 1'b1;
        do_store(50'h30, 64'h0, {16{32'hDEADBEEF}});
        for (int k = 0; k < 25; k++) begin
            if (l1d_req_vld_o !== 1'b0 || empty_o !== 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL zero_mask got %0d busy cycles expected 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        logic [LINE_W-1:0] d;
        int                seen;
        d = '0;
        d[63:0] = 64'h0123_4567_89AB_CDEF;
        seen = 0;
        l1d_req_rdy_i = 1'b0;
        do_store(50'h400, 64'hFF, d);
        do_store(50'h401, 64'hFF, d);
        for (int i = 0; i < 10 && !l1d_req_vld_o; i++) tick();
        checks++;
        if (l1d_req_vld_o !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got vld=%b expected 1", l1d_req_vld_o);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (l1d_req_vld_o !== 1'b0 || empty_o !== 1'b1 || st_req_rdy_o !== 1'b1 ||
            l1d_req_line_addr_o !== '0) begin
            failures++;
            $display("FAIL rstmid_state got vld=%b empty=%b rdy=%b addr=%h expected 0 1 1 0",
                     l1d_req_vld_o, empty_o, st_req_rdy_o, l1d_req_line_addr_o);
        end
        l1d_req_rdy_i = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (l1d_req_vld_o !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rstmid_nodrain got %0d valid cycles expected 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_single_timeout();
        test_merge();
        test_full_order();
        test_head_lock();
        test_flush();
        test_zero_mask();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
